// File: rtl/regfile_seq_pkg.sv
// Shared encodings and state type for the register-file sequencer.
package regfile_seq_pkg;
   localparam logic [1:0] OP_LDI  = 2'b00;
   localparam logic [1:0] OP_MOV  = 2'b01;
   localparam logic [1:0] OP_ADD  = 2'b10;
   localparam logic [1:0] OP_MISC = 2'b11;

   localparam logic [5:0] MISC_NOP  = 6'd0;
   localparam logic [5:0] MISC_HALT = 6'd1;

   typedef enum logic [2:0] {FETCH, IMM, EXEC1, EXEC2, HALTED} state_e;
endpackage

// File: rtl/regfile_sequencer.sv
// Multi-cycle control FSM for the two-register file: fetch/decode, immediate
// load, register move and add with carry.
module regfile_sequencer
   import regfile_seq_pkg::*;
#(
   parameter bit HALT_ON_ILLEGAL = 1'b1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       instr_valid,
   input  logic [7:0] instr,
   output logic       instr_ready,
   input  logic [7:0] rf_rdata,
   output logic       rf_rsel,
   output logic       rf_we,
   output logic       rf_waddr,
   output logic [7:0] rf_wdata,
   output logic       carry,
   output logic       retire,
   output logic       halted
);

   state_e     state_q, state_d;
   logic [7:0] ir_q, ir_d;
   logic [7:0] t_q, t_d;
   logic       carry_q, carry_d;
   logic [8:0] sum;
   logic       unused_ir;

   assign sum       = {1'b0, t_q} + {1'b0, rf_rdata};
   assign carry     = carry_q;
   assign unused_ir = ^ir_q[3:0];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= FETCH;
         ir_q    <= 8'h00;
         t_q     <= 8'h00;
         carry_q <= 1'b0;
      end else begin
         state_q <= state_d;
         ir_q    <= ir_d;
         t_q     <= t_d;
         carry_q <= carry_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      ir_d        = ir_q;
      t_d         = t_q;
      carry_d     = carry_q;
      instr_ready = 1'b0;
      rf_rsel     = 1'b0;
      rf_we       = 1'b0;
      rf_waddr    = 1'b0;
      rf_wdata    = 8'h00;
      retire      = 1'b0;
      halted      = 1'b0;
      unique case (state_q)
         FETCH: begin
            instr_ready = 1'b1;
            if (instr_valid) begin
               ir_d = instr;
               unique case (instr[7:6])
                  OP_LDI:         state_d = IMM;
                  OP_MOV, OP_ADD: state_d = EXEC1;
                  default: begin
                     retire = 1'b1;
                     if (instr[5:0] == MISC_HALT ||
                         (instr[5:0] != MISC_NOP && HALT_ON_ILLEGAL))
                        state_d = HALTED;
                  end
               endcase
            end
         end
         IMM: begin
            // Immediate byte goes straight to the write port, never decoded.
            instr_ready = 1'b1;
            if (instr_valid) begin
               rf_we    = 1'b1;
               rf_waddr = ir_q[5];
               rf_wdata = instr;
               retire   = 1'b1;
               state_d  = FETCH;
            end
         end
         EXEC1: begin
            rf_rsel = ir_q[4];
            if (ir_q[7:6] == OP_MOV) begin
               rf_we    = 1'b1;
               rf_waddr = ir_q[5];
               rf_wdata = rf_rdata;
               retire   = 1'b1;
               state_d  = FETCH;
            end else begin
               t_d     = rf_rdata;
               state_d = EXEC2;
            end
         end
         EXEC2: begin
            rf_rsel  = ir_q[5];
            rf_we    = 1'b1;
            rf_waddr = ir_q[5];
            rf_wdata = sum[7:0];
            carry_d  = sum[8];
            retire   = 1'b1;
            state_d  = FETCH;
         end
         HALTED: halted = 1'b1;
         default: state_d = FETCH;
      endcase
      // Registers already sit at their reset values; keep outputs quiet too.
      if (reset) begin
         instr_ready = 1'b1;
         rf_rsel     = 1'b0;
         rf_we       = 1'b0;
         rf_waddr    = 1'b0;
         rf_wdata    = 8'h00;
         retire      = 1'b0;
         halted      = 1'b0;
      end
   end

endmodule

// File: tb/tb_regfile_sequencer.sv
// Directed bench for regfile_sequencer with a behavioural two-entry register file.
module tb_regfile_sequencer;
   logic       clk, reset, instr_valid;
   logic [7:0] instr;
   logic       instr_ready, rf_rsel, rf_we, rf_waddr, carry, retire, halted;
   logic [7:0] rf_rdata, rf_wdata;
   logic       instr_ready0, rf_rsel0, rf_we0, rf_waddr0, carry0, retire0, halted0;
   logic [7:0] rf_rdata0, rf_wdata0;
   logic [7:0] regs [2];
   logic [7:0] regs0 [2];
   int         wr_cnt;
   int         tests, fails;
   int         w0;

   regfile_sequencer #(.HALT_ON_ILLEGAL(1'b1)) dut (
      .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr(instr),
      .instr_ready(instr_ready), .rf_rdata(rf_rdata), .rf_rsel(rf_rsel),
      .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
      .carry(carry), .retire(retire), .halted(halted));

   regfile_sequencer #(.HALT_ON_ILLEGAL(1'b0)) dut0 (
      .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr(instr),
      .instr_ready(instr_ready0), .rf_rdata(rf_rdata0), .rf_rsel(rf_rsel0),
      .rf_we(rf_we0), .rf_waddr(rf_waddr0), .rf_wdata(rf_wdata0),
      .carry(carry0), .retire(retire0), .halted(halted0));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign rf_rdata  = regs[rf_rsel];
   assign rf_rdata0 = regs0[rf_rsel0];

   initial begin
      regs[0] = 8'h00; regs[1] = 8'h00; regs0[0] = 8'h00; regs0[1] = 8'h00;
      wr_cnt = 0;
   end

   always @(posedge clk) begin
      if (rf_we) begin
         regs[rf_waddr] <= rf_wdata;
         wr_cnt <= wr_cnt + 1;
      end
      if (rf_we0) regs0[rf_waddr0] <= rf_wdata0;
   end

   task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [7:0] b);
      instr_valid = 1'b1;
      instr       = b;
      tick();
      instr_valid = 1'b0;
   endtask

   task automatic settle();
      #1;
   endtask

   initial begin
      tests = 0; fails = 0;
      reset = 1'b1; instr_valid = 1'b1; instr = 8'hC1;
      #2;
      chk("rst_ready",  instr_ready, 1);
      chk("rst_we",     rf_we, 0);
      chk("rst_retire", retire, 0);
      chk("rst_halted", halted, 0);
      chk("rst_carry",  carry, 0);
      chk("rst_wdata",  rf_wdata, 0);
      tick(); tick();
      reset = 1'b0; instr_valid = 1'b0;
      tick();

      // LDI R0, 0x5A
      instr_valid = 1'b1; instr = 8'h00; settle();
      chk("ldi_f_ready", instr_ready, 1);
      chk("ldi_f_we", rf_we, 0);
      chk("ldi_f_ret", retire, 0);
      tick();
      instr = 8'h5A; settle();
      chk("ldi_i_we", rf_we, 1);
      chk("ldi_i_waddr", rf_waddr, 0);
      chk("ldi_i_wdata", rf_wdata, 9'h5A);
      chk("ldi_i_ret", retire, 1);
      tick(); instr_valid = 1'b0;
      chk("ldi_r0", regs[0], 9'h5A);

      // R1=1, R0=FF, ADD R0,R1 wraps with carry
      send(8'h20); send(8'h01);
      send(8'h00); send(8'hFF);
      instr_valid = 1'b1; instr = 8'h90; settle();
      chk("add_f_ret", retire, 0);
      tick(); instr_valid = 1'b0; settle();
      chk("add_e1_rsel", rf_rsel, 1);
      chk("add_e1_we", rf_we, 0);
      tick();
      chk("add_e2_rsel", rf_rsel, 0);
      chk("add_e2_we", rf_we, 1);
      chk("add_e2_waddr", rf_waddr, 0);
      chk("add_e2_wdata", rf_wdata, 9'h00);
      chk("add_e2_ret", retire, 1);
      tick();
      chk("add_carry", carry, 1);
      chk("add_r0", regs[0], 9'h00);

      // MOV R1,R0 preserves carry
      send(8'h60);
      chk("mov_rsel", rf_rsel, 0);
      chk("mov_we", rf_we, 1);
      chk("mov_waddr", rf_waddr, 1);
      chk("mov_wdata", rf_wdata, 9'h00);
      chk("mov_ret", retire, 1);
      tick();
      chk("mov_carry", carry, 1);
      chk("mov_r1", regs[1], 9'h00);

      // ADD R1,R1 with R1=0x40 doubles, clears carry, single write
      send(8'h20); send(8'h40);
      w0 = wr_cnt;
      send(8'hB0);
      chk("dbl_e1_rsel", rf_rsel, 1);
      chk("dbl_e1_ret", retire, 0);
      tick();
      chk("dbl_e2_rsel", rf_rsel, 1);
      chk("dbl_e2_wdata", rf_wdata, 9'h80);
      chk("dbl_e2_waddr", rf_waddr, 1);
      chk("dbl_e2_ret", retire, 1);
      tick();
      chk("dbl_carry", carry, 0);
      chk("dbl_writes", 9'(wr_cnt - w0), 1);
      chk("dbl_r1", regs[1], 9'h80);

      // Stalls in FETCH and IMM
      w0 = wr_cnt;
      for (int i = 0; i < 5; i++) begin
         settle();
         chk("stall_f_ready", instr_ready, 1);
         chk("stall_f_ret", retire, 0);
         tick();
      end
      send(8'h00);
      for (int i = 0; i < 5; i++) begin
         settle();
         chk("stall_i_ready", instr_ready, 1);
         chk("stall_i_we", rf_we, 0);
         chk("stall_i_ret", retire, 0);
         tick();
      end
      chk("stall_writes", 9'(wr_cnt - w0), 0);
      instr_valid = 1'b1; instr = 8'h33; settle();
      chk("stall_res_wdata", rf_wdata, 9'h33);
      tick(); instr_valid = 1'b0;
      chk("stall_r0", regs[0], 9'h33);

      // HALT
      instr_valid = 1'b1; instr = 8'hC1; settle();
      chk("halt_ret", retire, 1);
      tick();
      w0 = wr_cnt;
      instr = 8'h00;
      for (int i = 0; i < 3; i++) begin
         settle();
         chk("halt_halted", halted, 1);
         chk("halt_ready", instr_ready, 0);
         chk("halt_ret_q", retire, 0);
         tick();
      end
      instr_valid = 1'b0;
      chk("halt_writes", 9'(wr_cnt - w0), 0);

      // Illegal 0xC2 halts only with HALT_ON_ILLEGAL=1
      reset = 1'b1; tick(); reset = 1'b0;
      chk("rst_unhalt", halted, 0);
      instr_valid = 1'b1; instr = 8'hC2; settle();
      chk("ill1_ret", retire, 1);
      chk("ill0_ret", retire0, 1);
      tick(); instr_valid = 1'b0;
      chk("ill1_halted", halted, 1);
      chk("ill0_halted", halted0, 0);
      chk("ill0_ready", instr_ready0, 1);

      // Reset during EXEC2
      reset = 1'b1; tick(); reset = 1'b0;
      send(8'h00); send(8'hC0);
      send(8'h80); tick(); tick();
      chk("pre_carry", carry, 1);
      chk("pre_r0", regs[0], 9'h80);
      w0 = wr_cnt;
      send(8'h80); tick();
      reset = 1'b1; settle();
      chk("rx2_we", rf_we, 0);
      chk("rx2_ret", retire, 0);
      chk("rx2_ready", instr_ready, 1);
      chk("rx2_carry", carry, 0);
      chk("rx2_ir", dut.ir_q, 0);
      tick(); reset = 1'b0;
      chk("rx2_writes", 9'(wr_cnt - w0), 0);
      chk("rx2_r0", regs[0], 9'h80);

      // Reset during IMM wait; next byte is decoded as a fresh instruction
      send(8'h20); settle();
      reset = 1'b1; settle();
      chk("rim_we", rf_we, 0);
      chk("rim_ready", instr_ready, 1);
      tick(); reset = 1'b0;
      instr_valid = 1'b1; instr = 8'hC0; settle();
      chk("rim_nop_ret", retire, 1);
      chk("rim_nop_we", rf_we, 0);
      tick(); instr_valid = 1'b0;
      chk("rim_writes", 9'(wr_cnt - w0), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
